// File: rtl/definesPkg.sv
// Shared types for the APB command master: FSM states and the
// command/response bundles at the default 32-bit bus width.
package definesPkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apbMstState_t;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } apbCmd_t;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } apbRsp_t;

endpackage

// File: rtl/apb_cmd_master.sv
// APB requester: one valid/ready command in, one APB transfer out,
// one valid/ready response back, with wait-state timeout.
module apb_cmd_master
    import definesPkg::*;
#(
    parameter int addrWidth = 32,
    parameter int dataWidth = 32,
    parameter int TIMEOUT   = 16
) (
    input  logic                 apbClk,
    input  logic                 rst,
    input  logic                 cmdValid,
    output logic                 cmdReady,
    input  logic                 cmdWrite,
    input  logic [addrWidth-1:0] cmdAddr,
    input  logic [dataWidth-1:0] cmdWdata,
    output logic                 rspValid,
    input  logic                 rspReady,
    output logic [dataWidth-1:0] rspData,
    output logic                 rspErr,
    output logic [addrWidth-1:0] PADDR,
    output logic                 PWRITE,
    output logic                 PSEL,
    output logic                 PENABLE,
    output logic [dataWidth-1:0] PWDATA,
    input  logic [dataWidth-1:0] PRDATA,
    input  logic                 PREADY,
    input  logic                 PSLVERR
);

    // Widths follow the instance parameters, not the package defaults.
    typedef struct packed {
        logic                 write;
        logic [addrWidth-1:0] addr;
        logic [dataWidth-1:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic [dataWidth-1:0] data;
        logic                 err;
    } rsp_t;

    localparam bit TO_EN = (TIMEOUT > 0);
    localparam int CW = TO_EN ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_LAST = TO_EN ? CW'(TIMEOUT - 1) : '0;

    apbMstState_t  state_q, state_d;
    logic [CW-1:0] waitCnt_q, waitCnt_d;
    cmd_t          cmd_q, cmd_d;
    rsp_t          rsp_q, rsp_d;

    always_ff @(posedge apbClk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            waitCnt_q <= '0;
            cmd_q     <= '0;
            rsp_q     <= '0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            cmd_q     <= cmd_d;
            rsp_q     <= rsp_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        waitCnt_d = waitCnt_q;
        cmd_d     = cmd_q;
        rsp_d     = rsp_q;
        unique case (state_q)
            IDLE: begin
                if (cmdValid) begin
                    cmd_d.write = cmdWrite;
                    cmd_d.addr  = cmdAddr;
                    cmd_d.wdata = cmdWdata;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                waitCnt_d = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // Completion beats a timeout landing on the same cycle.
                if (PREADY) begin
                    rsp_d.data = (!cmd_q.write && !PSLVERR) ? PRDATA : '0;
                    rsp_d.err  = PSLVERR;
                    state_d    = RESP;
                end else if (TO_EN && waitCnt_q == CNT_LAST) begin
                    rsp_d.data = '0;
                    rsp_d.err  = 1'b1;
                    state_d    = RESP;
                end else if (waitCnt_q != CNT_MAX) begin
                    waitCnt_d = waitCnt_q + 1'b1;
                end
            end
            RESP: begin
                if (rspReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmdReady = (state_q == IDLE) && !rst;
    assign PSEL     = (state_q == SETUP) || (state_q == ACCESS);
    assign PENABLE  = (state_q == ACCESS);
    assign rspValid = (state_q == RESP);
    assign rspData  = rsp_q.data;
    assign rspErr   = rsp_q.err;
    assign PADDR    = cmd_q.addr;
    assign PWRITE   = cmd_q.write;
    assign PWDATA   = cmd_q.wdata;

endmodule
